if_id_decode: RTL and testbench

IF/ID pipeline register and main decoder sitting directly downstream of the instruction fetch stage. Each cycle it captures the fetched `Inst` and `PC+4`, decodes the held instruction into register fields, a sign-extended immediate and main-control signals for the execute stage, and absorbs control hazards with a flush. It also detects load-use hazards and requests a one-cycle fetch stall, inserting a bubble toward execute.

---
 rtl/if_id_decode.sv | 198 +++++++++++++++++++
 tb/tb_if_id_decode.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/if_id_decode.sv
// if_id_decode: IF/ID pipeline register, main decoder and load-use hazard detector.
// Latency: instruction captured at edge N is decoded combinationally after edge N and consumed by execute at edge N+1.
// Backpressure: raises Stall for one cycle on a load-use hazard (fetch holds PC, IF/ID holds, a bubble is issued); Flush squashes.
//
// Ports:
//   Clk, Rst (async, active-high)      clock and reset
//   Inst, PC, Flush                    fetched instruction, its address, control-hazard squash from execute
//   Stall                              load-use stall request to fetch
//   ID_Valid, ID_PC4, ID_Inst          IF/ID register contents
//   rs, rt, rd, shamt, funct, Imm_SExt decoded fields of ID_Inst
//   RegDst..Jump, ALUOp, Illegal       main control, forced to 0 on a bubble
//
// Build option: define HAZARD_DETECT_EN to enable the load-use tracking register and stall.
// Without it Stall is tied to 0 and software must schedule around load-use hazards.

module if_id_decode (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Inst,
    input  logic [31:0] PC,
    input  logic        Flush,
    output logic        Stall,
    output logic        ID_Valid,
    output logic [31:0] ID_PC4,
    output logic [31:0] ID_Inst,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] Imm_SExt,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Jump,
    output logic [1:0]  ALUOp,
    output logic        Illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ---------------- IF/ID register ----------------
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (Flush) begin
            // Flush beats stall: the held instruction is on the wrong path.
            inst_d  = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!Stall) begin
            inst_d  = Inst;
            pc4_d   = PC + 32'd4;   // wraps modulo 2^32
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            inst_q  <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign ID_Inst  = inst_q;
    assign ID_PC4   = pc4_q;
    assign ID_Valid = valid_q;

    // ---------------- field extraction ----------------
    logic [5:0] opcode;
    assign opcode   = inst_q[31:26];
    assign rs       = inst_q[25:21];
    assign rt       = inst_q[20:16];
    assign rd       = inst_q[15:11];
    assign shamt    = inst_q[10:6];
    assign funct    = inst_q[5:0];
    assign Imm_SExt = {{16{inst_q[15]}}, inst_q[15:0]};

    // ---------------- main decoder (ungated) ----------------
    logic       dec_regdst, dec_alusrc, dec_memtoreg, dec_regwrite;
    logic       dec_memread, dec_memwrite, dec_branch, dec_jump, dec_illegal;
    logic [1:0] dec_aluop;

    always_comb begin
        dec_regdst   = 1'b0;
        dec_alusrc   = 1'b0;
        dec_memtoreg = 1'b0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_aluop    = 2'b00;
        dec_illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_regdst   = 1'b1;
                dec_regwrite = 1'b1;
                dec_aluop    = 2'b10;
            end
            OP_LW: begin
                dec_alusrc   = 1'b1;
                dec_memtoreg = 1'b1;
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
            end
            OP_SW: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec_branch   = 1'b1;
                dec_aluop    = 2'b01;
            end
            OP_ADDI: begin
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
            end
            OP_J: begin
                dec_jump     = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // A bubble goes to execute when nothing live is held or when stalling.
    logic bubble;
    assign bubble = !valid_q || Stall;

    assign RegDst   = dec_regdst   & ~bubble;
    assign ALUSrc   = dec_alusrc   & ~bubble;
    assign MemtoReg = dec_memtoreg & ~bubble;
    assign RegWrite = dec_regwrite & ~bubble;
    assign MemRead  = dec_memread  & ~bubble;
    assign MemWrite = dec_memwrite & ~bubble;
    assign Branch   = dec_branch   & ~bubble;
    assign Jump     = dec_jump     & ~bubble;
    assign ALUOp    = dec_aluop    & {2{~bubble}};
    assign Illegal  = dec_illegal  & ~bubble;

`ifdef HAZARD_DETECT_EN
    // ---------------- load-use tracking ----------------
    // Mirrors what execute received on the last edge. Flush does not clear
    // it: the instruction issued alongside a flush still reaches execute.
    logic       ex_memread_q, ex_memread_d;
    logic [4:0] ex_rt_q, ex_rt_d;

    always_comb begin
        ex_memread_d = MemRead;
        ex_rt_d      = bubble ? 5'd0 : rt;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ex_memread_q <= 1'b0;
            ex_rt_q      <= 5'd0;
        end else begin
            ex_memread_q <= ex_memread_d;
            ex_rt_q      <= ex_rt_d;
        end
    end

    logic uses_rs, uses_rt;
    always_comb begin
        uses_rs = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                  (opcode == OP_BEQ)   || (opcode == OP_ADDI);
        uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    end

    // Stall depends only on registered state and ID_Inst fields, never on
    // the gated controls, so there is no combinational loop through bubble.
    // $0 never carries a hazard since it is hardwired.
    assign Stall = valid_q && ex_memread_q && (ex_rt_q != 5'd0) &&
                   ((uses_rs && (rs == ex_rt_q)) || (uses_rt && (rt == ex_rt_q)));
`else
    assign Stall = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_decode.sv
module tb_if_id_decode;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] Inst = 32'd0;
    logic [31:0] PC = 32'd0;
    logic        Flush = 1'b0;
    logic        Stall, ID_Valid;
    logic [31:0] ID_PC4, ID_Inst, Imm_SExt;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, Illegal;
    logic [1:0]  ALUOp;

    if_id_decode dut (
        .Clk(Clk), .Rst(Rst), .Inst(Inst), .PC(PC), .Flush(Flush),
        .Stall(Stall), .ID_Valid(ID_Valid), .ID_PC4(ID_PC4), .ID_Inst(ID_Inst),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .Imm_SExt(Imm_SExt),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
        .ALUOp(ALUOp), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

`ifdef HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        stall;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference control table: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp[1:0],Illegal}
    function automatic logic [10:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'b000000: return 11'b1_0_0_1_0_0_0_0_10_0;
            6'b100011: return 11'b0_1_1_1_1_0_0_0_00_0;
            6'b101011: return 11'b0_1_0_0_0_1_0_0_00_0;
            6'b000100: return 11'b0_0_0_0_0_0_1_0_01_0;
            6'b001000: return 11'b0_1_0_1_0_0_0_0_00_0;
            6'b000010: return 11'b0_0_0_0_0_0_0_1_00_0;
            default:   return 11'b0_0_0_0_0_0_0_0_00_1;
        endcase
    endfunction

    task automatic cmp(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] i, input logic [31:0] p4,
                        input logic v, input logic s);
        exp_t e;
        e.inst = i; e.pc4 = p4; e.valid = v; e.stall = s; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        logic [10:0] c_exp, c_obs;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        c_exp = (e.valid && !e.stall) ? ref_ctrl(e.inst[31:26]) : 11'd0;
        c_obs = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, Illegal};
        cmp(e.tag, "ID_Valid", {31'd0, ID_Valid}, {31'd0, e.valid});
        cmp(e.tag, "Stall",    {31'd0, Stall},    {31'd0, e.stall});
        cmp(e.tag, "ID_Inst",  ID_Inst, e.inst);
        cmp(e.tag, "ID_PC4",   ID_PC4,  e.pc4);
        cmp(e.tag, "fields",   {7'd0, rs, rt, rd, shamt},
                               {7'd0, e.inst[25:21], e.inst[20:16], e.inst[15:11], e.inst[10:6]});
        cmp(e.tag, "funct",    {26'd0, funct}, {26'd0, e.inst[5:0]});
        cmp(e.tag, "Imm_SExt", Imm_SExt, {{16{e.inst[15]}}, e.inst[15:0]});
        cmp(e.tag, "ctrl",     {21'd0, c_obs}, {21'd0, c_exp});
    endtask

    // Drive one fetch slot, clock it, then compare the resulting ID stage.
    task automatic cyc(input string tag, input logic [31:0] i, input logic [31:0] p, input logic f,
                       input logic [31:0] ei, input logic [31:0] ep4, input logic ev, input logic es);
        Inst = i; PC = p; Flush = f;
        push(tag, ei, ep4, ev, es);
        @(posedge Clk);
        #1;
        check_front();
    endtask

    localparam logic [31:0] LW_A   = 32'h8C220004; // lw  $2,4($1)
    localparam logic [31:0] ADD_B  = 32'h00441820; // add $3,$2,$4
    localparam logic [31:0] ADDI_C = 32'h20060007; // addi $6,$0,7
    localparam logic [31:0] ADDI_D = 32'h2001FFFF; // addi $1,$0,-1
    localparam logic [31:0] LW_E   = 32'h8C200000; // lw  $0,0($1)
    localparam logic [31:0] ADD_F  = 32'h00001820; // add $3,$0,$0
    localparam logic [31:0] LW_G   = 32'h8C220000; // lw  $2,0($1)
    localparam logic [31:0] ADDI_H = 32'h20A20001; // addi $2,$5,1
    localparam logic [31:0] LW_I   = 32'h8C450000; // lw  $5,0($2)
    localparam logic [31:0] ADD_J  = 32'h00A53020; // add $6,$5,$5
    localparam logic [31:0] ILL_K  = 32'hFC000000; // opcode 111111
    localparam logic [31:0] J_L    = 32'h08000010; // j
    localparam logic [31:0] BEQ_M  = 32'h1022FFFE; // beq $1,$2,-2
    localparam logic [31:0] SW_N   = 32'hAC230008; // sw  $3,8($1)

    initial begin
        // reset state
        #3;
        push("reset", 32'd0, 32'd0, 1'b0, 1'b0);
        check_front();
        #4 Rst = 1'b0;

        cyc("lw_first",   LW_A,   32'h0,  1'b0, LW_A,   32'h4,  1'b1, 1'b0);
        cyc("loaduse",    ADD_B,  32'h4,  1'b0, ADD_B,  32'h8,  1'b1, HZ);
        if (HZ) cyc("after_stall", ADDI_C, 32'h8, 1'b0, ADD_B, 32'h8, 1'b1, 1'b0);
        else    cyc("after_stall", ADDI_C, 32'h8, 1'b0, ADDI_C, 32'hC, 1'b1, 1'b0);
        cyc("addi_c",     ADDI_C, 32'h8,  1'b0, ADDI_C, 32'hC,  1'b1, 1'b0);
        cyc("sext",       ADDI_D, 32'hC,  1'b0, ADDI_D, 32'h10, 1'b1, 1'b0);
        cyc("lw_r0",      LW_E,   32'h10, 1'b0, LW_E,   32'h14, 1'b1, 1'b0);
        cyc("use_r0",     ADD_F,  32'h14, 1'b0, ADD_F,  32'h18, 1'b1, 1'b0);
        cyc("lw_r2",      LW_G,   32'h18, 1'b0, LW_G,   32'h1C, 1'b1, 1'b0);
        cyc("addi_wr_r2", ADDI_H, 32'h1C, 1'b0, ADDI_H, 32'h20, 1'b1, 1'b0);
        // lw -> dependent lw -> dependent add
        cyc("b2b_lw1",    LW_G,   32'h20, 1'b0, LW_G,   32'h24, 1'b1, 1'b0);
        cyc("b2b_lw2",    LW_I,   32'h24, 1'b0, LW_I,   32'h28, 1'b1, HZ);
        if (HZ) cyc("b2b_hold", ADD_J, 32'h28, 1'b0, LW_I, 32'h28, 1'b1, 1'b0);
        else    cyc("b2b_hold", ADD_J, 32'h28, 1'b0, ADD_J, 32'h2C, 1'b1, 1'b0);
        cyc("b2b_add",    ADD_J,  32'h28, 1'b0, ADD_J,  32'h2C, 1'b1, HZ);
        // flush at the same edge as the stall
        cyc("flush",      ADD_J,  32'h28, 1'b1, 32'd0,  32'd0,  1'b0, 1'b0);
        cyc("illegal",    ILL_K,  32'h30, 1'b0, ILL_K,  32'h34, 1'b1, 1'b0);
        cyc("pc_wrap_j",  J_L,    32'hFFFFFFFC, 1'b0, J_L, 32'h0, 1'b1, 1'b0);
        cyc("beq",        BEQ_M,  32'h40, 1'b0, BEQ_M,  32'h44, 1'b1, 1'b0);
        cyc("sw",         SW_N,   32'h44, 1'b0, SW_N,   32'h48, 1'b1, 1'b0);
        // reset asserted mid-cycle during a stall
        cyc("pre_rst_lw", LW_G,   32'h0,  1'b0, LW_G,   32'h4,  1'b1, 1'b0);
        cyc("pre_rst_add", ADD_B, 32'h4,  1'b0, ADD_B,  32'h8,  1'b1, HZ);
        #2 Rst = 1'b1;
        #1;
        push("mid_reset", 32'd0, 32'd0, 1'b0, 1'b0);
        check_front();
        @(posedge Clk);
        #1;
        push("reset_held", 32'd0, 32'd0, 1'b0, 1'b0);
        check_front();
        #3 Rst = 1'b0;
        cyc("post_rst_lw",  LW_A,  32'h0, 1'b0, LW_A,  32'h4, 1'b1, 1'b0);
        cyc("post_rst_add", ADD_B, 32'h4, 1'b0, ADD_B, 32'h8, 1'b1, HZ);

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
